// File: rtl/bus_bridge_master_pkg.sv
// bus_bridge_master_pkg: state encoding and request-frame layout shared by the bridge master and slave
package bus_bridge_master_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_UTX} state_t;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;
    function automatic int frame_w(int aw, int dw);
        return aw + dw + 1;
    endfunction
    function automatic int data_lsb(int aw);
        return aw;
    endfunction
    function automatic int mode_bit(int aw, int dw);
        return aw + dw;
    endfunction
    function automatic int max_w(int a, int b);
        return a > b ? a : b;
    endfunction
    localparam int FRAME_W = frame_w(DEF_ADDR_WIDTH, DEF_DATA_WIDTH);
endpackage

// File: rtl/uart.sv
// uart: start/stop-framed serial transmitter and receiver, LSB first, with independent word widths
module uart #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int TX_DATA_WIDTH = 8,
    parameter int RX_DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TX_DATA_WIDTH-1:0] data_in,
    input  logic                     data_en,
    output logic                     tx,
    output logic                     tx_busy,
    input  logic                     rx,
    output logic                     ready,
    output logic [RX_DATA_WIDTH-1:0] data_out
);
    localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int TBW = $clog2(TX_DATA_WIDTH + 2);
    localparam int RBW = $clog2(RX_DATA_WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);

    logic [TX_DATA_WIDTH:0]   tx_sh;
    logic [RX_DATA_WIDTH-1:0] rx_sh;
    logic [CW-1:0]            tx_clk, rx_clk;
    logic [TBW-1:0]           tx_bit;
    logic [RBW-1:0]           rx_bit;
    logic [1:0]               rx_sync;
    logic                     rx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh <= '0;
            tx_clk <= '0;
            tx_bit <= '0;
        end else if (!tx_busy) begin
            if (data_en) begin
                tx <= 1'b0;
                tx_busy <= 1'b1;
                tx_sh <= {1'b1, data_in};
                tx_clk <= '0;
                tx_bit <= '0;
            end
        end else if (tx_clk != LAST) begin
            tx_clk <= tx_clk + 1'b1;
        end else begin
            tx_clk <= '0;
            tx_bit <= tx_bit + 1'b1;
            tx_busy <= tx_bit != TBW'(TX_DATA_WIDTH + 1);
            tx <= tx_bit == TBW'(TX_DATA_WIDTH + 1) ? 1'b1 : tx_sh[0];
            tx_sh <= tx_sh >> 1;
        end
    end

    // the bit timer starts half a bit in so every sample lands mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_busy <= 1'b0;
            rx_clk <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
            ready <= 1'b0;
            data_out <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            ready <= 1'b0;
            if (!rx_busy) begin
                rx_busy <= !rx_sync[1];
                rx_clk <= CW'(CLOCKS_PER_PULSE / 2);
                rx_bit <= '0;
            end else if (rx_clk != LAST) begin
                rx_clk <= rx_clk + 1'b1;
            end else begin
                rx_clk <= '0;
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == '0) begin
                    rx_busy <= !rx_sync[1];
                end else if (rx_bit == RBW'(RX_DATA_WIDTH + 1)) begin
                    rx_busy <= 1'b0;
                    ready <= rx_sync[1];
                    data_out <= rx_sh;
                end else begin
                    rx_sh <= {rx_sync[1], rx_sh[RX_DATA_WIDTH-1:1]};
                end
            end
        end
    end
endmodule

// File: rtl/bus_bridge_master.sv
// bus_bridge_master: replays UART-delivered request frames as serial bus transactions
// and returns read data to the remote slave bridge over UART.
module bus_bridge_master
    import bus_bridge_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int UART_CLOCKS_PER_PULSE = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic u_rx,
    output logic u_tx,
    output logic mbreq,
    input  logic mbgrant,
    output logic mwdata,
    output logic mmode,
    output logic mvalid,
    input  logic mrdata,
    input  logic svalid,
    input  logic msplit
);
    localparam int FW = frame_w(ADDR_WIDTH, DATA_WIDTH);
    localparam int SW = max_w(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW = $clog2(SW + 1);
    localparam int DL = data_lsb(ADDR_WIDTH);
    localparam int MB = mode_bit(ADDR_WIDTH, DATA_WIDTH);

    state_t                state;
    logic [FW-1:0]         rx_frame, pend, work;
    logic [SW-1:0]         sh;
    logic [DATA_WIDTH-1:0] rd;
    logic [CW-1:0]         cnt;
    logic                  rx_ready, pend_valid, split, data_en, tx_busy;

    uart #(
        .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE),
        .TX_DATA_WIDTH(DATA_WIDTH),
        .RX_DATA_WIDTH(FW)
    ) u_uart (
        .clk(clk),
        .rst(rst),
        .data_in(rd),
        .data_en(data_en),
        .tx(u_tx),
        .tx_busy(tx_busy),
        .rx(u_rx),
        .ready(rx_ready),
        .data_out(rx_frame)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pend <= '0;
            pend_valid <= 1'b0;
            work <= '0;
            sh <= '0;
            rd <= '0;
            cnt <= '0;
            split <= 1'b0;
            data_en <= 1'b0;
            mbreq <= 1'b0;
            mvalid <= 1'b0;
            mwdata <= 1'b0;
            mmode <= 1'b0;
        end else begin
            data_en <= 1'b0;
            if (rx_ready && !pend_valid) begin
                pend <= rx_frame;
                pend_valid <= 1'b1;
            end
            case (state)
                S_IDLE: if (pend_valid) begin
                    work <= pend;
                    pend_valid <= 1'b0;
                    mbreq <= 1'b1;
                    cnt <= '0;
                    state <= S_REQ;
                end
                S_REQ: if (mbgrant) begin
                    mvalid <= 1'b1;
                    mmode <= work[MB];
                    mwdata <= work[0];
                    sh <= SW'(work[ADDR_WIDTH-1:0] >> 1);
                    cnt <= '0;
                    state <= S_ADDR;
                end
                // grant loss is ignored here: a started transfer always runs to completion
                S_ADDR: if (cnt == CW'(ADDR_WIDTH - 1)) begin
                    cnt <= '0;
                    if (work[MB]) begin
                        mwdata <= work[DL];
                        sh <= SW'(work[DL +: DATA_WIDTH] >> 1);
                        state <= S_WDATA;
                    end else begin
                        mvalid <= 1'b0;
                        mwdata <= 1'b0;
                        state <= S_RWAIT;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    mwdata <= sh[0];
                    sh <= sh >> 1;
                end
                S_WDATA: if (cnt == CW'(DATA_WIDTH - 1)) begin
                    cnt <= '0;
                    mvalid <= 1'b0;
                    mwdata <= 1'b0;
                    mmode <= 1'b0;
                    mbreq <= 1'b0;
                    state <= S_IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                    mwdata <= sh[0];
                    sh <= sh >> 1;
                end
                // after a split, mbreq is low for one cycle and svalid is ignored until re-granted
                S_RWAIT: if (msplit) begin
                    mbreq <= 1'b0;
                    split <= 1'b1;
                end else if (split) begin
                    mbreq <= 1'b1;
                    split <= !(mbreq && mbgrant);
                end else if (svalid) begin
                    rd <= {mrdata, rd[DATA_WIDTH-1:1]};
                    cnt <= '0;
                    state <= S_RDATA;
                end
                S_RDATA: if (svalid) begin
                    rd <= {mrdata, rd[DATA_WIDTH-1:1]};
                    cnt <= cnt == CW'(DATA_WIDTH - 2) ? '0 : cnt + 1'b1;
                    mbreq <= cnt != CW'(DATA_WIDTH - 2);
                    state <= cnt == CW'(DATA_WIDTH - 2) ? S_UTX : S_RDATA;
                end
                S_UTX: if (!tx_busy) begin
                    data_en <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bus_bridge_master.md
BUS_BRIDGE_MASTER -- requirements
Module: bus_bridge_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, serial-bus data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, serial-bus address width.
REQ-003 SHALL have parameter UART_CLOCKS_PER_PULSE, default 5208, clocks per UART bit.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port u_rx, input, 1, UART line carrying request frames from the remote slave bridge.
REQ-007 SHALL have port u_tx, output, 1, UART line returning read data to the remote slave bridge.
REQ-008 SHALL have port mbreq, output, 1, bus request to the arbiter.
REQ-009 SHALL have port mbgrant, input, 1, bus grant from the arbiter.
REQ-010 SHALL have port mwdata, output, 1, serial write data and address to the slave.
REQ-011 SHALL have port mmode, output, 1, transaction mode (1=write, 0=read).
REQ-012 SHALL have port mvalid, output, 1, mwdata valid this cycle.
REQ-013 SHALL have port mrdata, input, 1, serial read data from the slave.
REQ-014 SHALL have port svalid, input, 1, mrdata valid this cycle.
REQ-015 SHALL have port msplit, input, 1, slave split: bus released, wait for re-grant.

Function
REQ-016 SHALL receive frames of width FRAME_W = ADDR_WIDTH+DATA_WIDTH+1 via UART: bits [ADDR_WIDTH-1:0] addr, next DATA_WIDTH bits data, MSB mode.
REQ-017 SHALL capture a frame on the UART ready pulse into a 1-entry pending register; a frame arriving while pending is full SHALL be dropped.
REQ-018 SHALL implement states IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, UTX.
REQ-019 IDLE -> REQ when pending is full; frame moves to the working register and pending clears in the same cycle.
REQ-020 REQ: mbreq=1; -> ADDR on first cycle with mbgrant=1.
REQ-021 ADDR: mvalid=1, mmode=frame mode, mwdata=addr bits LSB first, one bit per cycle for exactly ADDR_WIDTH cycles.
REQ-022 After ADDR: write -> WDATA, read -> RWAIT.
REQ-023 WDATA: mvalid=1, mwdata=data LSB first for exactly DATA_WIDTH cycles, then -> IDLE; mbreq drops the cycle after the last bit.
REQ-024 RWAIT: mvalid=0, mbreq=1; -> RDATA with the first svalid=1 cycle, whose mrdata is sampled as bit 0.
REQ-025 RDATA: sample mrdata LSB first only on svalid=1 cycles; -> UTX after DATA_WIDTH bits.
REQ-026 msplit=1 in RWAIT SHALL hold the state, drop mbreq for one cycle, then re-assert mbreq and resume waiting for svalid once mbgrant=1.
REQ-027 UTX: pulse UART data_en one cycle with the read byte when tx is not busy, then -> IDLE; the bus is released on UTX entry.
REQ-028 mbgrant deassertion during ADDR/WDATA SHALL NOT abort; transfer completes.
REQ-029 Bit counter width SHALL be clog2(max(ADDR_WIDTH,DATA_WIDTH)+1) and cleared on every state entry.
REQ-030 Outside ADDR/WDATA, mvalid=0 and mwdata=0.

Reset
REQ-031 rst=1 on any edge SHALL force IDLE, clear pending and working registers, clear counters, mbreq=0, mvalid=0, mwdata=0, mmode=0, and u_tx idle-high.
REQ-032 Reset mid-transaction SHALL discard the frame with no further bus or UART activity.

Structure
REQ-033 The shared package SHALL hold state encoding, FRAME_W, and the frame field offsets, shared with bus_bridge_slave.
REQ-034 The block SHALL instantiate one sub-module, the existing uart (TX_DATA_WIDTH=DATA_WIDTH, RX_DATA_WIDTH=FRAME_W).

Verification
REQ-035 Write frame mode=1, addr=0x9AA, data=0xD5, grant immediate -> mvalid high 20 cycles; mwdata = 0x9AA then 0xD5, both LSB first; mmode=1.
REQ-036 Read frame addr=0x9AA, slave returns 0xD4 after 5 idle cycles -> UART emits 0xD4 once; mmode=0; mvalid high 12 cycles only.
REQ-037 Grant delayed 10 cycles -> mbreq high throughout; no mvalid before grant.
REQ-038 Read with msplit pulse in RWAIT, re-grant after 4 cycles -> mbreq low exactly 1 cycle; 0xD4 still returned.
REQ-039 Three frames back-to-back during a long read -> second executes after the first, third dropped.
REQ-040 rst asserted at ADDR bit 5 -> next cycle all outputs at reset values; no UART transmission follows.
